// File: rtl/pipe_pkg.sv
// Shared types for the MEM->WB pipeline stage: occupancy encoding and the
// write-back payload shape at the default widths.
package pipe_pkg;

    localparam int PIPE_DATA_W     = 32;
    localparam int PIPE_REG_ADDR_W = 5;

    // Number of entries held by the elastic stage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Write-back payload; control bits first so a flush only touches the MSBs.
    typedef struct packed {
        logic                       mem_to_reg;
        logic                       reg_write;
        logic [PIPE_DATA_W-1:0]     dm_rdata;
        logic [PIPE_DATA_W-1:0]     wd;
        logic [PIPE_REG_ADDR_W-1:0] wr;
    } wb_payload_t;

endpackage

// File: rtl/wb_payload_reg.sv
// One write-back payload entry (used for both head and skid). Updates on the
// falling clock edge like the rest of the pipeline. A clear drops only the
// control bits; the data fields are left as they are.
module wb_payload_reg
    import pipe_pkg::*;
#(
    parameter type entry_t = wb_payload_t
)
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_clr,
    input  entry_t i_d,
    output entry_t o_q
);

    entry_t r_q;

    // Entry storage: reset zeroes everything, clear beats load.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q.mem_to_reg <= 1'b0;
            r_q.reg_write  <= 1'b0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// Elastic MEM->WB stage: 2-entry skid buffer (head + skid) with registered
// upstream ready, flush, and a write-enable that is gated by valid.
// Optional statistics counters are enabled with the PIPE_STAT_EN macro.
module wb_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = PIPE_DATA_W,
`ifdef PIPE_STAT_EN
    parameter int STAT_W     = 16,
`endif
    parameter int REG_ADDR_W = PIPE_REG_ADDR_W
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    input  logic [DATA_W-1:0]     in_dm_rdata,
    input  logic [DATA_W-1:0]     in_wd,
    input  logic [REG_ADDR_W-1:0] in_wr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mem_to_reg,
    output logic                  out_reg_write,
    output logic [DATA_W-1:0]     out_dm_rdata,
    output logic [DATA_W-1:0]     out_wd,
    output logic [REG_ADDR_W-1:0] out_wr
`ifdef PIPE_STAT_EN
    ,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stall_cnt,
    output logic [STAT_W-1:0]     bubble_cnt
`endif
);

    // Same field layout as wb_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [DATA_W-1:0]     dm_rdata;
        logic [DATA_W-1:0]     wd;
        logic [REG_ADDR_W-1:0] wr;
    } payload_t;

    occ_t     r_state;
    occ_t     w_state_next;
    logic     r_in_ready;
    logic     w_out_valid;
    logic     w_accept;
    logic     w_drain;
    logic     w_head_load;
    logic     w_head_from_skid;
    logic     w_skid_load;
    payload_t w_in_entry;
    payload_t w_head_d;
    payload_t w_head_q;
    payload_t w_skid_q;

    assign w_in_entry = '{mem_to_reg: in_mem_to_reg, reg_write: in_reg_write,
                          dm_rdata: in_dm_rdata, wd: in_wd, wr: in_wr};

    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & r_in_ready & ~flush;
    assign w_drain     = w_out_valid & out_ready;

    // Occupancy next-state and entry load controls; flush overrides everything.
    always_comb begin
        w_state_next     = r_state;
        w_head_load      = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ONE;
                        w_head_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_drain) begin
                        w_head_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = FULL;
                        w_skid_load  = 1'b1;
                    end else if (w_drain) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    // Skid refills the head so order is preserved.
                    if (w_drain) begin
                        w_state_next     = ONE;
                        w_head_load      = 1'b1;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready is registered from the next state.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != FULL);
        end
    end

    assign w_head_d = w_head_from_skid ? w_skid_q : w_in_entry;

    wb_payload_reg #(.entry_t(payload_t)) u_head (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_head_load),
        .i_clr  (flush),
        .i_d    (w_head_d),
        .o_q    (w_head_q)
    );

    wb_payload_reg #(.entry_t(payload_t)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_skid_load),
        .i_clr  (flush),
        .i_d    (w_in_entry),
        .o_q    (w_skid_q)
    );

    assign in_ready       = r_in_ready;
    assign out_valid      = w_out_valid;
    assign out_mem_to_reg = w_head_q.mem_to_reg;
    // A bubble must never write the register file.
    assign out_reg_write  = w_head_q.reg_write & w_out_valid;
    assign out_dm_rdata   = w_head_q.dm_rdata;
    assign out_wd         = w_head_q.wd;
    assign out_wr         = w_head_q.wr;

`ifdef PIPE_STAT_EN
    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; flush does not touch them.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
            if (!w_out_valid && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + STAT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage. Directed stimulus pushes expected
// payloads into a queue on accept; a monitor on the rising edge (the DUT
// updates on the falling edge) compares the presented head entry.
module tb_wb_pipe_stage;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mem_to_reg = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [31:0] in_dm_rdata = 32'h0;
    logic [31:0] in_wd = 32'h0;
    logic [4:0]  in_wr = 5'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_mem_to_reg;
    logic        out_reg_write;
    logic [31:0] out_dm_rdata;
    logic [31:0] out_wd;
    logic [4:0]  out_wr;
`ifdef PIPE_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;
    logic [15:0] m_stall = 16'h0;
    logic [15:0] m_bubble = 16'h0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          m_cnt = 0;
    wb_payload_t exp_q[$];

    always #5 clk = ~clk;

    wb_pipe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .in_dm_rdata    (in_dm_rdata),
        .in_wd          (in_wd),
        .in_wr          (in_wr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .out_dm_rdata   (out_dm_rdata),
        .out_wd         (out_wd),
        .out_wr         (out_wr)
`ifdef PIPE_STAT_EN
        ,
        .stat_clr       (stat_clr),
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference occupancy/scoreboard, advanced on the DUT's active edge.
    always @(negedge clk or posedge rst) begin : model
        bit acc;
        bit drn;
        if (rst) begin
            m_cnt = 0;
            exp_q.delete();
`ifdef PIPE_STAT_EN
            m_stall  = 16'h0;
            m_bubble = 16'h0;
`endif
        end else begin
            acc = in_valid && (m_cnt < 2) && !flush;
            drn = (m_cnt > 0) && out_ready;
`ifdef PIPE_STAT_EN
            if (stat_clr) begin
                m_stall  = 16'h0;
                m_bubble = 16'h0;
            end else begin
                if (m_cnt > 0 && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'h1;
                if (m_cnt == 0 && m_bubble != 16'hFFFF) m_bubble = m_bubble + 16'h1;
            end
`endif
            if (flush) begin
                m_cnt = 0;
                exp_q.delete();
            end else begin
                if (drn) begin
                    void'(exp_q.pop_front());
                    m_cnt = m_cnt - 1;
                end
                if (acc) begin
                    exp_q.push_back('{mem_to_reg: in_mem_to_reg, reg_write: in_reg_write,
                                      dm_rdata: in_dm_rdata, wd: in_wd, wr: in_wr});
                    m_cnt = m_cnt + 1;
                end
            end
        end
    end

    // Monitor: compare handshake outputs and the head entry mid-cycle.
    always @(posedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(m_cnt < 2));
            check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
            if (m_cnt > 0) begin
                check("out_wr", 32'(out_wr), 32'(exp_q[0].wr));
                check("out_wd", out_wd, exp_q[0].wd);
                check("out_dm_rdata", out_dm_rdata, exp_q[0].dm_rdata);
                check("out_mem_to_reg", 32'(out_mem_to_reg), 32'(exp_q[0].mem_to_reg));
                check("out_reg_write", 32'(out_reg_write), 32'(exp_q[0].reg_write));
            end else begin
                check("bubble_reg_write", 32'(out_reg_write), 32'h0);
            end
`ifdef PIPE_STAT_EN
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            check("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
`endif
        end
    end

    task automatic drive(input logic v, input logic m2r, input logic rw,
                         input logic [31:0] dm, input logic [31:0] wd, input logic [4:0] wr,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid      = v;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_dm_rdata   = dm;
        in_wd         = wd;
        in_wr         = wr;
        out_ready     = ordy;
        flush         = fl;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, ordy, 1'b0);
        end
    endtask

    initial begin
        // Reset state while rst is still held.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_reg_write", 32'(out_reg_write), 32'h0);
        check("rst_out_wr", 32'(out_wr), 32'h0);
        check("rst_out_wd", out_wd, 32'h0);
        #1;
        rst = 1'b0;
        idle(1'b1, 2);

        // Single entry, straight through.
        drive(1'b1, 1'b0, 1'b1, 32'h0000BEEF, 32'h00001234, 5'd3, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Back-to-back stream of 8 with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'(i & 1), 1'b1, 32'hD000 + i, 32'hA000 + 32'(i * 17), 5'(i + 8), 1'b1, 1'b0);
        end
        idle(1'b1, 3);

        // Back-pressure: A, B fill the stage, C is refused, then drain in order.
        drive(1'b1, 1'b1, 1'b1, 32'h11111111, 32'hAAAA0001, 5'd10, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h22222222, 32'hBBBB0002, 5'd11, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h33333333, 32'hCCCC0003, 5'd12, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 4);

        // Flush while FULL with a concurrent input.
        drive(1'b1, 1'b1, 1'b1, 32'h44444444, 32'hDDDD0004, 5'd13, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h55555555, 32'hEEEE0005, 5'd14, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'h66666666, 32'hFFFF0006, 5'd15, 1'b0, 1'b1);
        idle(1'b1, 3);

        // Asynchronous reset between edges while holding one entry.
        drive(1'b1, 1'b1, 1'b1, 32'h77777777, 32'h12340007, 5'd31, 1'b0, 1'b0);
        idle(1'b0, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h1);
        check("arst_out_reg_write", 32'(out_reg_write), 32'h0);
        check("arst_out_mem_to_reg", 32'(out_mem_to_reg), 32'h0);
        check("arst_out_wr", 32'(out_wr), 32'h0);
        check("arst_out_wd", out_wd, 32'h0);
        check("arst_out_dm_rdata", out_dm_rdata, 32'h0);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h88888888, 32'h56780008, 5'd7, 1'b1, 1'b0);
        idle(1'b1, 3);

`ifdef PIPE_STAT_EN
        // Clear, then stalls and bubbles, then saturation.
        @(posedge clk);
        #1;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h99999999, 32'h9ABC0009, 5'd9, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);
        drive(1'b1, 1'b0, 1'b1, 32'hAAAAAAAA, 32'h0000000A, 5'd1, 1'b0, 1'b0);
        idle(1'b0, 65541);
        @(posedge clk);
        check("stall_saturated", 32'(stall_cnt), 32'h0000FFFF);
        #1;
        idle(1'b1, 3);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
